// File: rtl/pipe_addsub.sv
// ----------------------------------------------------------------------------
// pipe_addsub
//
// Pipelined add/subtract unit. The WIDTH-bit carry chain is split into
// STAGES slices of S = WIDTH/STAGES bits. Each slice is added by a chain of
// 4-bit carry-lookahead blocks, and the slice carry-out is registered into
// the next stage. Operands that have not been added yet travel with the
// pipeline, and so do the sum slices that are already complete. A
// bubble-collapsing valid/ready handshake lets empty stages fill even while
// the output is stalled.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of 4*STAGES
//   STAGES  pipeline depth (>= 1); latency is STAGES cycles
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   operands present
//   in_ready_o   unit accepts operands this cycle
//   a_i, b_i     operands
//   cin_i        carry-in; used only for addition
//   sub_i        1: a_i - b_i, 0: a_i + b_i + cin_i
//   out_valid_o  result present
//   out_ready_i  consumer takes the result this cycle
//   sum_o        result
//   cout_o       carry out of the MSB (for subtraction, 1 = no borrow)
//   of_o         signed overflow
//   zero_o       sum_o == 0
// ----------------------------------------------------------------------------
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             of_o,
    output logic             zero_o
);

    localparam int S  = WIDTH / STAGES;  // slice width per stage
    localparam int NB = S / 4;           // CLA blocks per slice

    // 4-bit carry-lookahead block: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Per-stage register contents, exported from the generate blocks
    logic [STAGES-1:0]            v_w;
    logic [STAGES-1:0]            c_w;
    logic [STAGES-1:0]            load_w;
    logic [STAGES-1:0][WIDTH-1:0] a_w;
    logic [STAGES-1:0][WIDTH-1:0] bx_w;
    logic [STAGES-1:0][WIDTH-1:0] sum_w;
    logic [STAGES:0]              ready;

    // Next-state values from the final stage, for the flag registers
    logic             cmsb_d;
    logic [WIDTH-1:0] last_sum_d;
    logic             cmsb_q;
    logic             zero_q;

    // A stage can take new data if it is empty or its content moves on.
    // Computed in one block, from the output end backwards.
    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = !v_w[k] || ready[k+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             up_valid;
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] bx_in;
            logic [WIDTH-1:0] sum_in;
            logic             c_in;
            logic [S-1:0]     slice_sum;
            logic             c_out;
            logic             carry;
            logic [4:0]       blk;
            logic [WIDTH-1:0] sum_d;
            logic             v_q;
            logic             c_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] bx_q;
            logic [WIDTH-1:0] sum_q;

            if (gi == 0) begin : g_src_in
                // B is inverted once on entry; carry-in becomes 1 for SUB
                assign up_valid = in_valid_i;
                assign a_in     = a_i;
                assign bx_in    = sub_i ? ~b_i : b_i;
                assign c_in     = sub_i | cin_i;
                assign sum_in   = '0;
            end else begin : g_src_prev
                assign up_valid = v_w[gi-1];
                assign a_in     = a_w[gi-1];
                assign bx_in    = bx_w[gi-1];
                assign c_in     = c_w[gi-1];
                assign sum_in   = sum_w[gi-1];
            end

            // Add this stage's slice and splice it into the travelling sum
            always_comb begin
                carry     = c_in;
                slice_sum = '0;
                blk       = '0;
                for (int bi = 0; bi < NB; bi++) begin
                    blk = cla4(a_in[gi*S + 4*bi +: 4], bx_in[gi*S + 4*bi +: 4], carry);
                    slice_sum[4*bi +: 4] = blk[3:0];
                    carry = blk[4];
                end
                c_out = carry;
                sum_d = sum_in;
                sum_d[gi*S +: S] = slice_sum;
            end

            assign load_w[gi] = up_valid && ready[gi];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    a_q   <= '0;
                    bx_q  <= '0;
                    sum_q <= '0;
                end else begin
                    // When ready but upstream is empty, the stage drains to a bubble
                    if (ready[gi]) begin
                        v_q <= up_valid;
                    end
                    if (load_w[gi]) begin
                        c_q   <= c_out;
                        a_q   <= a_in;
                        bx_q  <= bx_in;
                        sum_q <= sum_d;
                    end
                end
            end

            assign v_w[gi]   = v_q;
            assign c_w[gi]   = c_q;
            assign a_w[gi]   = a_q;
            assign bx_w[gi]  = bx_q;
            assign sum_w[gi] = sum_q;

            if (gi == STAGES - 1) begin : g_msb
                // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c
                assign cmsb_d     = a_in[WIDTH-1] ^ bx_in[WIDTH-1] ^ slice_sum[S-1];
                assign last_sum_d = sum_d;
            end
        end
    endgenerate

    // MSB carry-in and zero flag are registered with the final stage so the
    // reset value of every flag is 0, not something derived from SUM=0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmsb_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (load_w[STAGES-1]) begin
            cmsb_q <= cmsb_d;
            zero_q <= ~|last_sum_d;
        end
    end

    // The final stage's operand copy has no reader
    logic unused_last_ops;
    assign unused_last_ops = ^{a_w[STAGES-1], bx_w[STAGES-1]};

    assign in_ready_o  = ready[0];
    assign out_valid_o = v_w[STAGES-1];
    assign sum_o       = sum_w[STAGES-1];
    assign cout_o      = c_w[STAGES-1];
    assign of_o        = cmsb_q ^ c_w[STAGES-1];
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// ----------------------------------------------------------------------------
// tb_pipe_addsub
//
// Self-checking bench for pipe_addsub. Expected results come from a plain
// arithmetic model (wide addition, sign rule for overflow) kept in a queue in
// acceptance order. Covers reset state, flag corner cases, carry across slice
// boundaries, latency, a backpressure stream with a fixed stall window,
// reset mid-stream, and a randomized stream with input bubbles and random
// output stalls. Override W/ST to sweep other configurations.
// ----------------------------------------------------------------------------
module tb_pipe_addsub #(
    parameter int W  = 32,
    parameter int ST = 4
);

    localparam int S = W / ST;

    typedef logic [W+2:0] res_t;  // {cout, of, zero, sum}

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         of;
    logic         zero;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .of_o        (of),
        .zero_o      (zero)
    );

    // Reference: two's-complement arithmetic on a W+1 bit sum
    function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic c, logic s);
        logic [W:0]   full;
        logic [W-1:0] yy;
        logic         ci;
        logic         ov;
        yy   = s ? ~y : y;
        ci   = s ? 1'b1 : c;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci};
        // overflow: operands share a sign and the result sign differs
        ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return {full[W], ov, (full[W-1:0] == '0), full[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_res(string tag, res_t e);
        chk({tag, ".sum"},  128'(sum),  128'(e[W-1:0]));
        chk({tag, ".cout"}, 128'(cout), 128'(e[W+2]));
        chk({tag, ".of"},   128'(of),   128'(e[W+1]));
        chk({tag, ".zero"}, 128'(zero), 128'(e[W]));
    endtask

    // One isolated operation: checks acceptance, latency and result
    task automatic single(string tag, logic [W-1:0] x, logic [W-1:0] y, logic c, logic s);
        int   lat;
        res_t e;
        e = model(x, y, c, s);
        @(negedge clk);
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < ST + 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 128'(lat), 128'(ST));
        chk_res(tag, e);
        $display("%s: a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b of=%0b zero=%0b lat=%0d",
                 tag, x, y, c, s, sum, cout, of, zero, lat);
    endtask

    // Streams nops random operations. rnd=0: back-to-back with OUT_READY low
    // in cycles 5..7; rnd=1: random input gaps and random output stalls.
    task automatic stream(string tag, int nops, bit rnd);
        res_t         e_q[$];
        logic [W-1:0] xa, xb;
        logic         xc, xs;
        int           acc, got, occ, cyc;
        bit           have;
        acc = 0; got = 0; occ = 0; cyc = 0; have = 1'b0;
        xa = '0; xb = '0; xc = 1'b0; xs = 1'b0;
        while (got < nops && cyc < 400) begin
            @(negedge clk);
            if (!have && acc < nops && (!rnd || $urandom_range(3) != 0)) begin
                xa = rnd_w(); xb = rnd_w();
                xc = 1'($urandom_range(1)); xs = 1'($urandom_range(1));
                have = 1'b1;
            end
            in_valid = have;
            a = xa; b = xb; cin = xc; sub = xs;
            out_ready = rnd ? ($urandom_range(2) != 0) : !(cyc >= 5 && cyc <= 7);
            #1;
            // Input is refused only when every stage holds a result and none leaves
            chk({tag, ".in_ready"}, 128'(in_ready), 128'((occ < ST) || out_ready));
            if (out_valid) begin
                if (e_q.size() == 0) begin
                    chk({tag, ".spurious"}, 128'(out_valid), 128'(1'b0));
                end else begin
                    chk_res(tag, e_q[0]);
                    if (out_ready) begin
                        $display("%s: result %0d sum=%h cout=%0b of=%0b zero=%0b",
                                 tag, got, sum, cout, of, zero);
                        void'(e_q.pop_front());
                        got++;
                        occ--;
                    end
                end
            end
            if (have && in_ready) begin
                e_q.push_back(model(xa, xb, xc, xs));
                acc++;
                occ++;
                have = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, ".count"}, 128'(got), 128'(nops));
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(1'b0));
        chk({tag, ".sum"},       128'(sum),       128'(0));
        chk({tag, ".cout"},      128'(cout),      128'(1'b0));
        chk({tag, ".of"},        128'(of),        128'(1'b0));
        chk({tag, ".zero"},      128'(zero),      128'(1'b0));
        chk({tag, ".in_ready"},  128'(in_ready),  128'(1'b1));
    endtask

    initial begin
        logic [W-1:0] maxpos, minneg, ones, lo_slice;
        maxpos   = {1'b0, {(W-1){1'b1}}};
        minneg   = {1'b1, {(W-1){1'b0}}};
        ones     = '1;
        lo_slice = '0;
        for (int i = 0; i < S; i++) lo_slice[i] = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        chk_reset_state("reset_init");
        $display("reset_init: out_valid=%0b sum=%h in_ready=%0b", out_valid, sum, in_ready);

        // Release just after an edge: the next rising edge accepts the first op
        @(posedge clk);
        #1 rst = 1'b0;

        single("add_ovf",       maxpos,   W'(1), 1'b0, 1'b0);
        single("add_wrap",      ones,     W'(1), 1'b0, 1'b0);
        single("sub_5_7",       W'(5),    W'(7), 1'b0, 1'b1);
        single("sub_min_1",     minneg,   W'(1), 1'b0, 1'b1);
        single("sub_5_7_cin",   W'(5),    W'(7), 1'b1, 1'b1);
        single("sub_min_1_cin", minneg,   W'(1), 1'b1, 1'b1);
        single("slice_carry",   lo_slice, W'(1), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            single($sformatf("rand%0d", i), rnd_w(), rnd_w(),
                   1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        stream("bp", 8, 1'b0);

        // Reset with operations in flight
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = rnd_w(); b = rnd_w(); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_state("reset_mid");
        $display("reset_mid: out_valid=%0b sum=%h in_ready=%0b", out_valid, sum, in_ready);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < ST + 4; i++) begin
            @(negedge clk);
            #1;
            chk("reset_mid.stale", 128'(out_valid), 128'(1'b0));
        end

        stream("rnd", 24, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined add/subtract unit built from 4-bit carry-lookahead slices, with a valid/ready handshake and full status flags (carry, signed overflow, zero). It replaces the fixed 32-bit combinational ripple-of-CLA adder in the execute path where timing closure needs the carry chain split across registers. It also serves as a stand-alone adder for multi-cycle datapath variants.

## Interface
- WIDTH, 32: operand/result width. Must be a multiple of 4*STAGES.
- STAGES, 4: pipeline depth. Must be ≥1. Each stage adds a WIDTH/STAGES-bit slice using (WIDTH/STAGES)/4 chained 4-bit CLA blocks.

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- IN_VALID  in  1  operands present
- IN_READY  out  1  unit accepts operands this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- CIN  in  1  carry-in, used only when SUB=0
- SUB  in  1  1: A-B (B inverted, carry-in forced 1, CIN ignored); 0: A+B+CIN
- OUT_VALID  out  1  result present
- OUT_READY  in  1  consumer takes result this cycle
- SUM  out  WIDTH  result
- COUT  out  1  carry out of MSB. For SUB, 1 means no borrow.
- OF  out  1  signed overflow, computed as carry into MSB XOR carry out of MSB
- ZERO  out  1  SUM == 0

## Operation
- Stage k (0..STAGES-1) adds slice k = bits [(k+1)*S-1 : k*S], with S = WIDTH/STAGES.
  - Its carry-in is stage k-1's registered carry-out. Stage 0 uses CIN, or 1 when SUB=1.
- Operand skew:
  - Upper operand slices (B already inverted for SUB) travel unmodified through stage registers until their stage.
  - Completed lower sum slices travel forward alongside them.
- The final stage also registers the MSB carry-in and carry-out, for OF and COUT.
- ZERO is computed from the final registered SUM (combinational or registered; in either case valid whenever OUT_VALID=1).
- Per-stage valid bit v[k]. Each stage register is the output of stage k, so SUM/flags come from stage STAGES-1.
- Handshake, bubble-collapsing:
  - ready[STAGES] = OUT_READY
  - ready[k] = !v[k] || ready[k+1]
  - IN_READY = ready[0]
  - A stage loads when its upstream holds valid data and ready[k] is high. Otherwise it holds.
  - A transfer occurs on IN_VALID && IN_READY, and on OUT_VALID && OUT_READY.
- IN_READY depends combinationally on OUT_READY. This is accepted; callers must not make OUT_READY depend on IN_READY.
- Results emerge strictly in input order, none dropped or duplicated.
- Reset (any time, including mid-operation):
  - All v[k]=0, all data/flag registers 0, in-flight operations discarded.
  - Outputs: OUT_VALID=0, SUM=0, COUT=0, OF=0, ZERO=0 (gated by reset value, not recomputed). IN_READY=1.

## Timing
- Latency: STAGES cycles from the accepting edge to OUT_VALID=1, when unstalled. STAGES=1 gives a one-cycle registered adder.
- Throughput: one operation per cycle while OUT_READY=1.
- Holding: while OUT_VALID=1 and OUT_READY=0, SUM/COUT/OF/ZERO stay stable.
- Filling:
  - Bubbles in lower stages still fill.
  - When all STAGES stages are valid and OUT_READY=0, IN_READY=0 in that same cycle.
- Simultaneous accept and drain while full: both transfers occur in the same cycle, with no bubble inserted.
- Reset release: the first operand can be accepted on the first rising edge with RST=0.

## Test plan
- Reset: assert RST mid-stream with 3 ops in flight, then release. OUT_VALID=0, SUM=0, flags 0, IN_READY=1. No stale result appears afterwards.
- Add flags (WIDTH=32, STAGES=4):
  - 0x7FFFFFFF+0x00000001, CIN=0 → after 4 cycles SUM=0x80000000, OF=1, COUT=0, ZERO=0.
  - 0xFFFFFFFF+0x00000001 → SUM=0, COUT=1, OF=0, ZERO=1.
- Subtract:
  - 5−7 → SUM=0xFFFFFFFE, COUT=0, OF=0.
  - 0x80000000−1 → SUM=0x7FFFFFFF, COUT=1, OF=1.
  - CIN=1 with SUB=1 must not alter either result.
- Carry across slice boundaries: 0x0000FFFF+0x00000001 with CIN=1 → SUM=0x00010001. Confirms inter-stage carry registers.
- Backpressure: stream 8 random ops back-to-back, hold OUT_READY=0 for cycles 5–7.
  - IN_READY drops once 4 ops are held.
  - All 8 results match a reference model, in order, with none lost or duplicated.
  - SUM is stable while stalled.
- Parameter sweep: repeat the flag and backpressure tests for (WIDTH,STAGES) = (16,1), (16,2), (64,8). Latency equals STAGES and results match the model.
